// File: rtl/axi_eth_rx_pkg.sv
// Shared receive-path constants and helpers.
//   Ethernet II: EtherType codes, header length, broadcast MAC.
//   IPv4: version, minimum header length (32-bit words), protocol numbers.
//   eth_type_supported(): EtherTypes the parser forwards to a consumer.
package axi_eth_rx_pkg;

    localparam logic [15:0] ETH_TYPE_IPV4  = 16'h0800;
    localparam logic [15:0] ETH_TYPE_ARP   = 16'h0806;
    localparam int          ETH_HDR_LENGTH = 14;
    localparam logic [47:0] MAC_BCAST      = 48'hffff_ffff_ffff;

    localparam logic [3:0]  IP_VERSION     = 4'd4;
    localparam logic [3:0]  IP_HDR_LENGTH  = 4'd5;
    localparam logic [7:0]  IP_PROTO_ICMP  = 8'd1;
    localparam logic [7:0]  IP_PROTO_TCP   = 8'd6;
    localparam logic [7:0]  IP_PROTO_UDP   = 8'd17;

    function automatic logic eth_type_supported(input logic [15:0] etype);
        return (etype == ETH_TYPE_IPV4) || (etype == ETH_TYPE_ARP);
    endfunction

endpackage

// File: rtl/axi_eth_rx_sat_counter.sv
// Saturating event counter: holds at all-ones instead of wrapping.
//   clk, rst_n : clock, asynchronous active-low reset
//   clear_i    : synchronous clear (wins over inc_i)
//   inc_i      : count one event this cycle
//   count_o    : current count
module sat_counter
    import axi_eth_rx_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear_i,
    input  logic             inc_i,
    output logic [WIDTH-1:0] count_o
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // next count: clear first, then increment unless already saturated
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (inc_i && (count_q != {WIDTH{1'b1}})) begin
            count_d = count_q + WIDTH'(1);
        end else begin
            count_d = count_q;
        end
    end

    // counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/axi_eth_rx.sv
// Ethernet II receive parser (FCS already stripped upstream).
// Consumes the 14-byte header, filters on destination MAC and EtherType,
// and forwards the payload with zero latency to the IPv4 or ARP stream.
//   s_axis_*      : byte stream from the MAC
//   eth_valid     : header accepted, held until the frame's tlast beat
//   eth_dst_mac/eth_src_mac/eth_type : last captured header fields
//   ip_axis_*     : IPv4 payload stream;  arp_axis_* : ARP payload stream
//   cnt_rx_frames : frames fully received; cnt_rx_dropped : frames dropped
module axi_eth_rx
    import axi_eth_rx_pkg::*;
#(
    parameter bit          DEBUG        = 1'b1,
    parameter logic [23:0] MAC_MSB      = 24'h010203,
    parameter logic [23:0] MAC_LSB      = 24'h040506,
    parameter bit          ACCEPT_BCAST = 1'b1,
    parameter int          CNT_WIDTH    = 16
) (
    input  logic                 clk,
    input  logic                 aresetn,
    input  logic                 s_axis_tvalid,
    input  logic [7:0]           s_axis_tdata,
    input  logic                 s_axis_tlast,
    output logic                 s_axis_tready,
    output logic                 eth_valid,
    output logic [47:0]          eth_dst_mac,
    output logic [47:0]          eth_src_mac,
    output logic [15:0]          eth_type,
    output logic                 ip_axis_tvalid,
    output logic [7:0]           ip_axis_tdata,
    output logic                 ip_axis_tlast,
    input  logic                 ip_axis_tready,
    output logic                 arp_axis_tvalid,
    output logic [7:0]           arp_axis_tdata,
    output logic                 arp_axis_tlast,
    input  logic                 arp_axis_tready,
    output logic [CNT_WIDTH-1:0] cnt_rx_frames,
    output logic [CNT_WIDTH-1:0] cnt_rx_dropped
);

    typedef enum logic [1:0] {
        S_HEADER  = 2'd0,
        S_PAYLOAD = 2'd1,
        S_SKIP    = 2'd2
    } state_t;

    localparam logic [47:0] OWN_MAC  = {MAC_MSB, MAC_LSB};
    localparam logic [3:0]  HDR_LAST = 4'(ETH_HDR_LENGTH - 1);
    // The header print is done by simulation monitors watching eth_valid;
    // nothing in the datapath depends on DEBUG.
    localparam bit debug_unused = DEBUG;

    state_t      state_q, state_d;
    logic [3:0]  idx_q, idx_d;
    logic [47:0] dst_q, dst_d;
    logic [47:0] src_q, src_d;
    logic [15:0] type_q, type_d;
    logic        eth_valid_q, eth_valid_d;

    logic        tready_s;
    logic        beat_s;
    logic        hdr_last_s;
    logic [15:0] type_cur_s;
    logic        accept_s;
    logic        frame_inc_s;
    logic        drop_inc_s;

    assign beat_s     = s_axis_tvalid && tready_s;
    assign hdr_last_s = (idx_q == HDR_LAST);
    // Header bytes shift in MSB first, so at byte 13 the first type byte
    // sits in the low half of type_q and the second is on the bus.
    assign type_cur_s = {type_q[7:0], s_axis_tdata};
    assign accept_s   = ((dst_q == OWN_MAC) || (ACCEPT_BCAST && (dst_q == MAC_BCAST)))
                        && eth_type_supported(type_cur_s);

    // Every tlast beat ends a frame whatever the state; drops happen only
    // in the header (runt, or failed filter). A runt at byte 13 is one drop.
    assign frame_inc_s = beat_s && s_axis_tlast;
    assign drop_inc_s  = beat_s && (state_q == S_HEADER)
                         && (s_axis_tlast || (hdr_last_s && !accept_s));

    // state register
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= S_HEADER;
        end else begin
            state_q <= state_d;
        end
    end

    // next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_HEADER: begin
                if (beat_s && !s_axis_tlast && hdr_last_s) begin
                    state_d = accept_s ? S_PAYLOAD : S_SKIP;
                end else begin
                    state_d = S_HEADER;
                end
            end
            S_PAYLOAD, S_SKIP: begin
                if (beat_s && s_axis_tlast) begin
                    state_d = S_HEADER;
                end else begin
                    state_d = state_q;
                end
            end
            default: state_d = S_HEADER;
        endcase
    end

    // output logic: payload routing is combinational, zero latency
    always_comb begin
        tready_s        = 1'b0;
        ip_axis_tvalid  = 1'b0;
        arp_axis_tvalid = 1'b0;
        case (state_q)
            S_HEADER: tready_s = 1'b1;
            S_PAYLOAD: begin
                if (type_q == ETH_TYPE_IPV4) begin
                    ip_axis_tvalid = s_axis_tvalid;
                    tready_s       = ip_axis_tready;
                end else if (type_q == ETH_TYPE_ARP) begin
                    arp_axis_tvalid = s_axis_tvalid;
                    tready_s        = arp_axis_tready;
                end else begin
                    tready_s = 1'b0;
                end
            end
            S_SKIP:  tready_s = 1'b1;
            default: tready_s = 1'b0;
        endcase
    end

    // Input is never ready while reset is held, even though the state
    // register already shows S_HEADER.
    assign s_axis_tready  = tready_s && aresetn;
    assign ip_axis_tdata  = s_axis_tdata;
    assign ip_axis_tlast  = s_axis_tlast;
    assign arp_axis_tdata = s_axis_tdata;
    assign arp_axis_tlast = s_axis_tlast;

    // header capture, byte index and eth_valid next values
    always_comb begin
        idx_d       = idx_q;
        dst_d       = dst_q;
        src_d       = src_q;
        type_d      = type_q;
        eth_valid_d = eth_valid_q;
        if (beat_s && (state_q == S_HEADER)) begin
            if (idx_q < 4'd6) begin
                dst_d = {dst_q[39:0], s_axis_tdata};
            end else if (idx_q < 4'd12) begin
                src_d = {src_q[39:0], s_axis_tdata};
            end else begin
                type_d = {type_q[7:0], s_axis_tdata};
            end
            if (s_axis_tlast || hdr_last_s) begin
                idx_d = 4'd0;
            end else begin
                idx_d = idx_q + 4'd1;
            end
            eth_valid_d = hdr_last_s && !s_axis_tlast && accept_s;
        end else if (beat_s && s_axis_tlast) begin
            eth_valid_d = 1'b0;
        end else begin
            eth_valid_d = eth_valid_q;
        end
    end

    // header and index registers
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            idx_q       <= 4'd0;
            dst_q       <= 48'd0;
            src_q       <= 48'd0;
            type_q      <= 16'd0;
            eth_valid_q <= 1'b0;
        end else begin
            idx_q       <= idx_d;
            dst_q       <= dst_d;
            src_q       <= src_d;
            type_q      <= type_d;
            eth_valid_q <= eth_valid_d;
        end
    end

    assign eth_valid   = eth_valid_q;
    assign eth_dst_mac = dst_q;
    assign eth_src_mac = src_q;
    assign eth_type    = type_q;

    sat_counter #(.WIDTH(CNT_WIDTH)) u_cnt_frames (
        .clk     (clk),
        .rst_n   (aresetn),
        .clear_i (1'b0),
        .inc_i   (frame_inc_s),
        .count_o (cnt_rx_frames)
    );

    sat_counter #(.WIDTH(CNT_WIDTH)) u_cnt_dropped (
        .clk     (clk),
        .rst_n   (aresetn),
        .clear_i (1'b0),
        .inc_i   (drop_inc_s),
        .count_o (cnt_rx_dropped)
    );

endmodule

// File: tb/tb_axi_eth_rx.sv
// Directed bench for axi_eth_rx: payload beats are predicted into queues
// as frames are driven and popped when the DUT presents them.
module tb_axi_eth_rx;
    import axi_eth_rx_pkg::*;

    localparam logic [47:0] OWN     = 48'h0102_0304_0506;
    localparam logic [47:0] FOREIGN = 48'h0102_0304_0507;
    localparam logic [47:0] SRC     = 48'h0a0b_0c0d_0e0f;

    logic clk = 1'b0;
    logic aresetn = 1'b0;
    always #5 clk = ~clk;

    logic        s_tvalid, s_tlast, s_tready;
    logic [7:0]  s_tdata;
    logic        eth_valid;
    logic [47:0] eth_dst, eth_src;
    logic [15:0] eth_type;
    logic        ip_tvalid, ip_tlast, ip_tready;
    logic [7:0]  ip_tdata;
    logic        arp_tvalid, arp_tlast, arp_tready;
    logic [7:0]  arp_tdata;
    logic [15:0] cnt_frames, cnt_drop;
    logic        arp_toggle;

    // second instance with 2-bit counters for saturation
    logic        s2_tvalid, s2_tlast, s2_tready;
    logic [7:0]  s2_tdata;
    logic        e2_valid, ip2_tvalid, ip2_tlast, arp2_tvalid, arp2_tlast;
    logic [47:0] e2_dst, e2_src;
    logic [15:0] e2_type;
    logic [7:0]  ip2_tdata, arp2_tdata;
    logic [1:0]  cnt2_frames, cnt2_drop;

    int n_vec = 0;
    int n_err = 0;
    int exp_frames = 0;
    int exp_drop = 0;
    logic [8:0] ip_q[$];
    logic [8:0] arp_q[$];
    logic [7:0] frm[$];

    axi_eth_rx dut (
        .clk(clk), .aresetn(aresetn),
        .s_axis_tvalid(s_tvalid), .s_axis_tdata(s_tdata), .s_axis_tlast(s_tlast),
        .s_axis_tready(s_tready),
        .eth_valid(eth_valid), .eth_dst_mac(eth_dst), .eth_src_mac(eth_src), .eth_type(eth_type),
        .ip_axis_tvalid(ip_tvalid), .ip_axis_tdata(ip_tdata), .ip_axis_tlast(ip_tlast),
        .ip_axis_tready(ip_tready),
        .arp_axis_tvalid(arp_tvalid), .arp_axis_tdata(arp_tdata), .arp_axis_tlast(arp_tlast),
        .arp_axis_tready(arp_tready),
        .cnt_rx_frames(cnt_frames), .cnt_rx_dropped(cnt_drop)
    );

    axi_eth_rx #(.CNT_WIDTH(2)) dut_sat (
        .clk(clk), .aresetn(aresetn),
        .s_axis_tvalid(s2_tvalid), .s_axis_tdata(s2_tdata), .s_axis_tlast(s2_tlast),
        .s_axis_tready(s2_tready),
        .eth_valid(e2_valid), .eth_dst_mac(e2_dst), .eth_src_mac(e2_src), .eth_type(e2_type),
        .ip_axis_tvalid(ip2_tvalid), .ip_axis_tdata(ip2_tdata), .ip_axis_tlast(ip2_tlast),
        .ip_axis_tready(1'b1),
        .arp_axis_tvalid(arp2_tvalid), .arp_axis_tdata(arp2_tdata), .arp_axis_tlast(arp2_tlast),
        .arp_axis_tready(1'b1),
        .cnt_rx_frames(cnt2_frames), .cnt_rx_dropped(cnt2_drop)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // header print on each accepted header
    always @(posedge eth_valid)
        $display("hdr accepted: dst %h src %h type %h", eth_dst, eth_src, eth_type);

    // scoreboard: outputs sampled on the falling edge, transfer at the next rise
    always @(negedge clk) begin
        logic [8:0] exp_beat;
        if (ip_tvalid && ip_tready) begin
            if (ip_q.size() == 0) begin
                check("ip_pending_beats", 64'(ip_q.size()), 64'd1);
            end else begin
                exp_beat = ip_q.pop_front();
                check("ip_beat", {ip_tlast, ip_tdata}, exp_beat);
            end
        end
        if (arp_tvalid) begin
            check("arp_ready_mirror", s_tready, arp_tready);
            check("ip_idle_during_arp", ip_tvalid, 1'b0);
        end
        if (arp_tvalid && arp_tready) begin
            if (arp_q.size() == 0) begin
                check("arp_pending_beats", 64'(arp_q.size()), 64'd1);
            end else begin
                exp_beat = arp_q.pop_front();
                check("arp_beat", {arp_tlast, arp_tdata}, exp_beat);
            end
        end
    end

    // consumer ready for ARP: toggles every cycle when enabled
    initial begin
        forever begin
            @(posedge clk);
            #2;
            arp_tready = arp_toggle ? ~arp_tready : 1'b1;
        end
    end

    task automatic send_byte(input logic [7:0] d, input logic l);
        int guard;
        guard = 0;
        s_tvalid = 1'b1;
        s_tdata  = d;
        s_tlast  = l;
        forever begin
            @(negedge clk);
            if (s_tready) break;
            guard++;
            if (guard >= 1000) begin
                check("send_timeout", 64'(guard), 64'd0);
                break;
            end
        end
        @(posedge clk);
        #1;
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
    endtask

    task automatic build_frame(input logic [47:0] dst, input logic [47:0] src,
                               input logic [15:0] etype, input int plen, input logic [7:0] p0);
        frm.delete();
        for (int i = 0; i < 6; i++) frm.push_back(dst[47-8*i -: 8]);
        for (int i = 0; i < 6; i++) frm.push_back(src[47-8*i -: 8]);
        frm.push_back(etype[15:8]);
        frm.push_back(etype[7:0]);
        for (int i = 0; i < plen; i++) frm.push_back(p0 + 8'(i));
    endtask

    // full frame: model the filter, predict beats and counters, drive, check eth_valid
    task automatic run_frame(input logic [47:0] dst, input logic [47:0] src,
                             input logic [15:0] etype, input int plen, input logic [7:0] p0);
        logic acc;
        build_frame(dst, src, etype, plen, p0);
        acc = ((dst == OWN) || (dst == 48'hffff_ffff_ffff))
              && ((etype == 16'h0800) || (etype == 16'h0806));
        for (int i = 0; i < plen; i++) begin
            if (acc && etype == 16'h0800) ip_q.push_back({(i == plen - 1), frm[14+i]});
            if (acc && etype == 16'h0806) arp_q.push_back({(i == plen - 1), frm[14+i]});
        end
        exp_frames++;
        if (!acc) exp_drop++;
        for (int i = 0; i < 14; i++) send_byte(frm[i], 1'b0);
        check("eth_valid_after_hdr", eth_valid, acc);
        for (int i = 14; i < frm.size(); i++) send_byte(frm[i], (i == frm.size() - 1));
        check("eth_valid_after_end", eth_valid, 1'b0);
    endtask

    initial begin
        s_tvalid = 1'b0; s_tdata = 8'h00; s_tlast = 1'b0;
        s2_tvalid = 1'b0; s2_tdata = 8'h00; s2_tlast = 1'b0;
        ip_tready = 1'b1; arp_tready = 1'b1; arp_toggle = 1'b0;
        aresetn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_tready", s_tready, 1'b0);
        check("rst_eth_valid", eth_valid, 1'b0);
        check("rst_type", eth_type, 16'h0000);
        check("rst_frames", cnt_frames, 16'd0);
        check("rst_dropped", cnt_drop, 16'd0);
        aresetn = 1'b1;
        @(posedge clk);
        #1;
        check("tready_header", s_tready, 1'b1);

        // unicast IPv4, 20-byte payload
        run_frame(OWN, SRC, ETH_TYPE_IPV4, 20, 8'h45);
        check("t1_type", eth_type, 16'h0800);
        check("t1_dst", eth_dst, OWN);
        check("t1_src", eth_src, SRC);
        check("t1_frames", cnt_frames, 64'(exp_frames));
        check("t1_dropped", cnt_drop, 64'(exp_drop));

        // broadcast ARP, consumer ready toggling
        arp_toggle = 1'b1;
        run_frame(MAC_BCAST, SRC, ETH_TYPE_ARP, 28, 8'h80);
        arp_toggle = 1'b0;
        check("t2_type", eth_type, 16'h0806);
        check("t2_arp_drained", 64'(arp_q.size()), 64'd0);

        // foreign MAC, then unsupported EtherType to own MAC
        run_frame(FOREIGN, SRC, ETH_TYPE_IPV4, 10, 8'h20);
        check("t3_dst_foreign", eth_dst, FOREIGN);
        run_frame(OWN, SRC, 16'h86dd, 10, 8'h30);
        check("t3_type_86dd", eth_type, 16'h86dd);
        check("t3_frames", cnt_frames, 64'(exp_frames));
        check("t3_dropped", cnt_drop, 64'(exp_drop));

        // runt with tlast at byte 9, then a good IPv4 frame
        build_frame(OWN, SRC, ETH_TYPE_IPV4, 20, 8'h10);
        for (int i = 0; i < 10; i++) send_byte(frm[i], (i == 9));
        exp_frames++;
        exp_drop++;
        check("t4_runt_no_valid", eth_valid, 1'b0);
        check("t4_runt_frames", cnt_frames, 64'(exp_frames));
        check("t4_runt_dropped", cnt_drop, 64'(exp_drop));
        run_frame(OWN, 48'h1112_1314_1516, ETH_TYPE_IPV4, 20, 8'h50);
        check("t4_src", eth_src, 48'h1112_1314_1516);
        check("t4_frames", cnt_frames, 64'(exp_frames));
        check("t4_dropped", cnt_drop, 64'(exp_drop));

        // reset during payload beat 5 of 20
        build_frame(OWN, SRC, ETH_TYPE_IPV4, 20, 8'h60);
        for (int i = 0; i < 20; i++) ip_q.push_back({(i == 19), frm[14+i]});
        for (int i = 0; i < 19; i++) send_byte(frm[i], 1'b0);
        check("t5_valid_mid", eth_valid, 1'b1);
        s_tvalid = 1'b1;
        s_tdata  = frm[19];
        #1;
        check("t5_ip_tvalid_pre", ip_tvalid, 1'b1);
        aresetn = 1'b0;
        #1;
        check("t5_ip_tvalid_rst", ip_tvalid, 1'b0);
        check("t5_tready_rst", s_tready, 1'b0);
        check("t5_valid_rst", eth_valid, 1'b0);
        check("t5_frames_rst", cnt_frames, 16'd0);
        check("t5_dropped_rst", cnt_drop, 16'd0);
        ip_q.delete();
        exp_frames = 0;
        exp_drop = 0;
        s_tvalid = 1'b0;
        @(posedge clk);
        #1;
        aresetn = 1'b1;
        run_frame(OWN, SRC, ETH_TYPE_IPV4, 12, 8'h70);
        check("t5_type", eth_type, 16'h0800);
        check("t5_frames", cnt_frames, 64'(exp_frames));
        check("t5_dropped", cnt_drop, 64'(exp_drop));
        check("ip_drained", 64'(ip_q.size()), 64'd0);

        // 2-bit counters: five dropped frames saturate at 3
        for (int f = 0; f < 5; f++) begin
            build_frame(FOREIGN, SRC, ETH_TYPE_IPV4, 4, 8'h00);
            for (int i = 0; i < frm.size(); i++) begin
                s2_tvalid = 1'b1;
                s2_tdata  = frm[i];
                s2_tlast  = (i == frm.size() - 1);
                @(negedge clk);
                check("t6_tready", s2_tready, 1'b1);
                @(posedge clk);
                #1;
            end
            s2_tvalid = 1'b0;
            s2_tlast  = 1'b0;
            check("t6_sat_dropped", cnt2_drop, (f >= 2) ? 64'd3 : 64'(f + 1));
        end
        check("t6_sat_frames", cnt2_frames, 2'd3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
